memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter RAM_AW, default 8, data RAM address width (2^RAM_AW x 16-bit words).
REQ-002 Parameter UART_BASE, default 16'hFF00, base address of the UART register window.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset asserted when low.
REQ-005 MemWriteM, MemToRegM, RegWriteM  input  1 each  control from the EX/MEM register.
REQ-006 destAddM  input  4  destination register address.
REQ-007 alu_resultM  input  16  memory address, or result passed through to writeback.
REQ-008 writeDataM  input  16  store data.
REQ-009 stallM  output  1  combinational; high freezes all upstream pipeline registers.
REQ-010 uart_tx_data  output  8  byte offered to the UART transmitter.
REQ-011 uart_tx_valid  output  1  high while a byte is offered.
REQ-012 uart_tx_ready  input  1  transmitter accepts the byte when ready and valid are both high at a rising edge.
REQ-013 uart_rx_data  input  8  received byte, qualified by uart_rx_valid.
REQ-014 uart_rx_valid  input  1  one-cycle pulse marking a received byte.
REQ-015 RegWriteW, MemToRegW  output  1 each  MEM/WB control.
REQ-016 destAddW  output  4  MEM/WB destination register address.
REQ-017 alu_resultW, read_dataW  output  16 each  MEM/WB data.

Function
REQ-018 Address decode: alu_resultM < 2^RAM_AW selects RAM; UART_BASE+0 is TXDATA (write only), +1 is STATUS (read only), +2 is RXDATA (read only); all other addresses are unmapped.
REQ-019 RAM: synchronous write of writeDataM when MemWriteM=1, RAM is selected and stallM=0; read is combinational; contents are not reset.
REQ-020 Loads: read_dataW captures the selected source one cycle after M; unmapped reads, TXDATA reads and writes to read-only registers return or do nothing, with unmapped and TXDATA reads returning 16'h0000.
REQ-021 STATUS read value: {13'b0, overrun, rx_pending, tx_free}; UART byte reads are zero-extended to 16 bits.
REQ-022 TX FSM: two states, IDLE and BUSY; uart_tx_valid=1 only in BUSY.
REQ-023 IDLE->BUSY on a TXDATA write with stallM=0; uart_tx_data loads writeDataM[7:0] on the same edge.
REQ-024 BUSY->IDLE on an edge where uart_tx_ready=1; uart_tx_data holds stable throughout BUSY.
REQ-025 tx_free = (state==IDLE); stallM = MemWriteM & TXDATA selected & (state==BUSY); stallM is based on state only, so a write coincident with handshake completion still stalls that cycle.
REQ-026 RX: on uart_rx_valid=1, the byte is captured into rx_buf and rx_pending is set.
REQ-027 A RXDATA read (MemToRegM=1, stallM=0) clears rx_pending.
REQ-028 If uart_rx_valid coincides with a RXDATA read, the read returns the old rx_buf; the new byte is captured and rx_pending stays 1.
REQ-029 uart_rx_valid arriving while rx_pending=1 and no RXDATA read is in progress overwrites rx_buf and sets overrun.
REQ-030 A STATUS read clears overrun, unless a new overrun occurs in the same cycle, in which case overrun stays 1.
REQ-031 MEM/WB register: when stallM=0, it loads RegWriteM, MemToRegM, destAddM, alu_resultM and the load data; latency is one cycle.
REQ-032 When stallM=1, the MEM/WB register inserts a bubble: RegWriteW=0 and MemToRegW=0, with other fields don't-care; the stalled instruction completes on the first unstalled cycle.

Reset
REQ-033 Reset (reset=0) asynchronously forces RegWriteW, MemToRegW, destAddW, alu_resultW, read_dataW, uart_tx_data, rx_buf, rx_pending and overrun to 0, and the TX FSM to IDLE (uart_tx_valid=0).
REQ-034 Reset during BUSY abandons the byte, with no further valid; RAM contents are unaffected.
REQ-035 Reset release is sampled on the rising edge; the first edge with reset=1 performs normal operation.

Verification
REQ-036 Store 16'hBEEF to 0x0010, then load 0x0010 -> read_dataW=16'hBEEF and MemToRegW=1 one cycle after the load is in M.
REQ-037 Write 0x41 to 16'hFF00 with uart_tx_ready=0 for 3 cycles, then 1 -> valid=1 with data 8'h41 for 4 cycles, then IDLE; a second TXDATA write during BUSY holds stallM=1 and inserts bubbles until the first byte is accepted.
REQ-038 uart_rx_valid with 8'h5A -> STATUS reads 16'h0003 (rx_pending and tx_free set); a RXDATA read returns 16'h005A; a subsequent STATUS read returns 16'h0001.
REQ-039 Two rx pulses (8'h11, 8'h22) with no read -> STATUS=16'h0007; a second STATUS read returns 16'h0003; RXDATA returns 16'h0022.
REQ-040 Load from 16'h1234 (unmapped) -> read_dataW=0; a store to it leaves RAM unchanged.
REQ-041 Assert reset mid-BUSY with rx_pending=1 -> all outputs are 0 immediately; after release, STATUS=16'h0001.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: data RAM, memory-mapped UART TX/RX registers and MEM/WB register.
// A TXDATA store while the transmitter is busy stalls upstream.
module memory_stage #(
    parameter int          RAM_AW    = 8,
    parameter logic [15:0] UART_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemToRegM,
    input  logic        RegWriteM,
    input  logic [3:0]  destAddM,
    input  logic [15:0] alu_resultM,
    input  logic [15:0] writeDataM,
    output logic        stallM,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic [3:0]  destAddW,
    output logic [15:0] alu_resultW,
    output logic [15:0] read_dataW
);

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  BUSY      = 1'b1;
    localparam logic [15:0] TX_ADDR   = UART_BASE;
    localparam logic [15:0] STAT_ADDR = UART_BASE + 16'd1;
    localparam logic [15:0] RX_ADDR   = UART_BASE + 16'd2;

    logic [15:0] ram [2**RAM_AW];
    logic [0:0]  txState;
    logic [7:0]  rxBuf;
    logic        rxPending;
    logic        overrun;
    logic        ramSel;
    logic        txSel;
    logic        statSel;
    logic        rxSel;
    logic        txFree;
    logic        txWrite;
    logic        rxRead;
    logic        statRead;
    logic        newOverrun;
    logic [15:0] loadData;

    assign ramSel  = (alu_resultM >> RAM_AW) == 16'd0;
    assign txSel   = alu_resultM == TX_ADDR;
    assign statSel = alu_resultM == STAT_ADDR;
    assign rxSel   = alu_resultM == RX_ADDR;

    assign txFree        = txState == IDLE;
    assign uart_tx_valid = txState == BUSY;
    // Stall depends on state only: a store coinciding with the handshake still waits.
    assign stallM        = MemWriteM & txSel & (txState == BUSY);

    assign txWrite    = MemWriteM & txSel & ~stallM;
    assign rxRead     = MemToRegM & rxSel & ~stallM;
    assign statRead   = MemToRegM & statSel & ~stallM;
    assign newOverrun = uart_rx_valid & rxPending & ~rxRead;

    always_comb begin
        loadData = '0;
        unique case (1'b1)
            ramSel:  loadData = ram[alu_resultM[RAM_AW-1:0]];
            statSel: loadData = {13'b0, overrun, rxPending, txFree};
            rxSel:   loadData = {8'b0, rxBuf};
            default: loadData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (MemWriteM & ramSel & ~stallM)
            ram[alu_resultM[RAM_AW-1:0]] <= writeDataM;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txState      <= IDLE;
            uart_tx_data <= '0;
        end else begin
            unique case (txState)
                IDLE: if (txWrite) begin
                    txState      <= BUSY;
                    uart_tx_data <= writeDataM[7:0];
                end
                BUSY: if (uart_tx_ready) txState <= IDLE;
                default: txState <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxBuf     <= '0;
            rxPending <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A read racing a new byte returns the old byte; the new one stays pending.
            if (uart_rx_valid) begin
                rxBuf     <= uart_rx_data;
                rxPending <= 1'b1;
            end else if (rxRead) begin
                rxPending <= 1'b0;
            end
            if (newOverrun)
                overrun <= 1'b1;
            else if (statRead)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteW   <= 1'b0;
            MemToRegW   <= 1'b0;
            destAddW    <= '0;
            alu_resultW <= '0;
            read_dataW  <= '0;
        end else if (stallM) begin
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM;
            MemToRegW   <= MemToRegM;
            destAddW    <= destAddM;
            alu_resultW <= alu_resultM;
            read_dataW  <= loadData;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: RAM, unmapped decode, UART TX stall,
// RX pending/overrun behaviour and asynchronous reset.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemToRegM;
    logic        RegWriteM;
    logic [3:0]  destAddM;
    logic [15:0] alu_resultM;
    logic [15:0] writeDataM;
    logic        stallM;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        RegWriteW;
    logic        MemToRegW;
    logic [3:0]  destAddW;
    logic [15:0] alu_resultW;
    logic [15:0] read_dataW;

    int checks = 0;
    int errors = 0;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
        .RegWriteM(RegWriteM), .destAddM(destAddM),
        .alu_resultM(alu_resultM), .writeDataM(writeDataM),
        .stallM(stallM),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .destAddW(destAddW), .alu_resultW(alu_resultW),
        .read_dataW(read_dataW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setM(input logic we, input logic mr, input logic rw,
                        input logic [15:0] addr, input logic [15:0] wd);
        MemWriteM   = we;
        MemToRegM   = mr;
        RegWriteM   = rw;
        destAddM    = 4'd5;
        alu_resultM = addr;
        writeDataM  = wd;
    endtask

    task automatic clearM();
        setM(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        destAddM = 4'd0;
    endtask

    task automatic issue(input logic we, input logic mr, input logic rw,
                         input logic [15:0] addr, input logic [15:0] wd);
        setM(we, mr, rw, addr, wd);
        step();
        clearM();
    endtask

    task automatic load(input logic [15:0] addr);
        issue(1'b0, 1'b1, 1'b1, addr, 16'h0000);
    endtask

    task automatic rxPulse(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        step();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clearM();
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        #3 reset = 1'b0;
        #1;
        check("rst_regwrite", {15'b0, RegWriteW}, 16'h0000);
        check("rst_memtoreg", {15'b0, MemToRegW}, 16'h0000);
        check("rst_readdata", read_dataW, 16'h0000);
        check("rst_alures", alu_resultW, 16'h0000);
        check("rst_txvalid", {15'b0, uart_tx_valid}, 16'h0000);
        check("rst_txdata", {8'b0, uart_tx_data}, 16'h0000);
        check("rst_stall", {15'b0, stallM}, 16'h0000);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // RAM store / load
        issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        load(16'h0010);
        check("ram_load", read_dataW, 16'hBEEF);
        check("ram_memtoreg", {15'b0, MemToRegW}, 16'h0001);
        check("ram_regwrite", {15'b0, RegWriteW}, 16'h0001);
        check("ram_dest", {12'b0, destAddW}, 16'h0005);
        check("ram_alures", alu_resultW, 16'h0010);

        // Unmapped and TXDATA reads
        issue(1'b1, 1'b0, 1'b0, 16'h0034, 16'h5555);
        issue(1'b1, 1'b0, 1'b0, 16'h1234, 16'hDEAD);
        load(16'h1234);
        check("unmapped_load", read_dataW, 16'h0000);
        load(16'h0034);
        check("unmapped_store_noalias", read_dataW, 16'h5555);
        load(16'hFF00);
        check("txdata_read", read_dataW, 16'h0000);

        // TX: write 0x41, second write during BUSY stalls
        issue(1'b1, 1'b0, 1'b0, 16'hFF00, 16'h0041);
        setM(1'b1, 1'b0, 1'b1, 16'hFF00, 16'h0042);
        for (int i = 1; i <= 4; i++) begin
            uart_tx_ready = (i == 4);
            #1;
            check($sformatf("tx_stall_%0d", i), {15'b0, stallM}, 16'h0001);
            check($sformatf("tx_valid_%0d", i), {15'b0, uart_tx_valid}, 16'h0001);
            check($sformatf("tx_data_%0d", i), {8'b0, uart_tx_data}, 16'h0041);
            step();
            check($sformatf("tx_bubble_%0d", i), {15'b0, RegWriteW}, 16'h0000);
        end
        check("tx_idle_nostall", {15'b0, stallM}, 16'h0000);
        check("tx_idle_novalid", {15'b0, uart_tx_valid}, 16'h0000);
        step();
        clearM();
        check("tx2_complete", {15'b0, RegWriteW}, 16'h0001);
        check("tx2_valid", {15'b0, uart_tx_valid}, 16'h0001);
        check("tx2_data", {8'b0, uart_tx_data}, 16'h0042);
        step();
        uart_tx_ready = 1'b0;
        check("tx2_done", {15'b0, uart_tx_valid}, 16'h0000);

        // RX single byte
        rxPulse(8'h5A);
        load(16'hFF01);
        check("rx_status1", read_dataW, 16'h0003);
        load(16'hFF02);
        check("rx_data1", read_dataW, 16'h005A);
        load(16'hFF01);
        check("rx_status2", read_dataW, 16'h0001);

        // RX overrun
        rxPulse(8'h11);
        rxPulse(8'h22);
        load(16'hFF01);
        check("ovr_status1", read_dataW, 16'h0007);
        load(16'hFF01);
        check("ovr_status2", read_dataW, 16'h0003);
        load(16'hFF02);
        check("ovr_data", read_dataW, 16'h0022);

        // RXDATA read racing a new byte
        rxPulse(8'h33);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h44;
        load(16'hFF02);
        uart_rx_valid = 1'b0;
        check("race_old", read_dataW, 16'h0033);
        load(16'hFF01);
        check("race_status", read_dataW, 16'h0003);
        load(16'hFF02);
        check("race_new", read_dataW, 16'h0044);

        // STATUS read coincident with a new overrun keeps overrun
        rxPulse(8'h55);
        rxPulse(8'h56);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h66;
        load(16'hFF01);
        uart_rx_valid = 1'b0;
        check("ovr_keep_rd", read_dataW, 16'h0007);
        load(16'hFF01);
        check("ovr_keep", read_dataW, 16'h0007);
        load(16'hFF01);
        check("ovr_cleared", read_dataW, 16'h0003);
        load(16'hFF02);
        check("ovr_keep_data", read_dataW, 16'h0066);

        // Reset mid-BUSY with rx pending
        rxPulse(8'h77);
        issue(1'b1, 1'b0, 1'b1, 16'hFF00, 16'h0099);
        check("pre_rst_valid", {15'b0, uart_tx_valid}, 16'h0001);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {15'b0, uart_tx_valid}, 16'h0000);
        check("mid_rst_txdata", {8'b0, uart_tx_data}, 16'h0000);
        check("mid_rst_regwrite", {15'b0, RegWriteW}, 16'h0000);
        check("mid_rst_alures", alu_resultW, 16'h0000);
        check("mid_rst_dest", {12'b0, destAddW}, 16'h0000);
        check("mid_rst_stall", {15'b0, stallM}, 16'h0000);
        @(posedge clk);
        #1;
        check("rst_hold_valid", {15'b0, uart_tx_valid}, 16'h0000);
        @(negedge clk) reset = 1'b1;
        load(16'hFF01);
        check("post_rst_status", read_dataW, 16'h0001);
        check("post_rst_valid", {15'b0, uart_tx_valid}, 16'h0000);
        load(16'h0010);
        check("post_rst_ram", read_dataW, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
